// File: rtl/bus_memory_model.sv
// -----------------------------------------------------------------------------
// bus_memory_model
//
// Clocked memory responder for the top8227 external bus. One CPU access is
// serviced per completed bus cycle; programmable wait states stretch each
// access by holding `ready` low. The upper address region is read-only to
// the CPU, a side-band port preloads memory (even during reset), and
// completed opcode fetches are counted.
//
// clk is expected to be the inverted CPU clock, so the model updates on the
// CPU's falling edge.
//
// Ports:
//   clk            model clock
//   nrst           synchronous active-low reset
//   address        CPU address {addressBusHigh, addressBusLow}
//   readNotWrite   1 = read, 0 = write
//   dataBusOutput  CPU write data
//   sync           CPU opcode-fetch indicator
//   dataBusInput   registered read data to the CPU
//   ready          access complete; CPU holds its bus while low
//   loadEn         side-band preload strobe
//   loadAddr       preload address
//   loadData       preload data
//   romWriteErr    one-cycle pulse: CPU write into the ROM region was dropped
//   fetchCount     completed sync=1 reads, wraps FFFF -> 0000
// -----------------------------------------------------------------------------
module bus_memory_model #(
    parameter int                ADDR_W          = 16,
    parameter int                DATA_W          = 8,
    parameter int                WAIT_STATES     = 0,
    parameter int                WAIT_FETCH_ONLY = 0,
    parameter logic [ADDR_W-1:0] ROM_BASE        = 16'hC000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] address,
    input  logic              readNotWrite,
    input  logic [DATA_W-1:0] dataBusOutput,
    input  logic              sync,
    output logic [DATA_W-1:0] dataBusInput,
    output logic              ready,
    input  logic              loadEn,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [DATA_W-1:0] loadData,
    output logic              romWriteErr,
    output logic [15:0]       fetchCount
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } stateType;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    stateType   state;
    logic [3:0] waitCnt;

    logic needWait;
    logic completing;
    logic deferWrite;
    logic cpuWrite;

    always_comb begin
        needWait   = (WAIT_STATES > 0) && ((WAIT_FETCH_ONLY == 0) || (sync == 1'b1));
        // An access completes either straight from IDLE (no stall needed) or
        // on the last counted stall edge.
        completing = (state == ST_IDLE) ? !needWait : (waitCnt == 4'd1);
        // The memory has a single write port; a preload on the same edge wins
        // and the CPU write is pushed back one edge.
        deferWrite = completing && !readNotWrite && loadEn;
        cpuWrite   = nrst && completing && !readNotWrite && !loadEn && (address < ROM_BASE);
    end

    // Memory array: one write port shared by preload and CPU, registered read
    // in the control block below. Reset deliberately leaves contents alone.
    always_ff @(posedge clk) begin
        if (loadEn) begin
            mem[loadAddr] <= loadData;
        end else if (cpuWrite) begin
            mem[address] <= dataBusOutput;
        end
    end

    always_ff @(posedge clk) begin
        romWriteErr <= 1'b0;
        if (!nrst) begin
            state        <= ST_IDLE;
            ready        <= 1'b1;
            waitCnt      <= 4'd0;
            dataBusInput <= '0;
            fetchCount   <= 16'd0;
        end else if (deferWrite) begin
            // Park in WAIT with one edge left so the write completes next edge
            // (or is deferred again if the preload is still active).
            state   <= ST_WAIT;
            ready   <= 1'b0;
            waitCnt <= 4'd1;
        end else if (completing) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            waitCnt <= 4'd0;
            if (readNotWrite) begin
                // Read sees the pre-edge contents even if a preload hits the
                // same address at this edge.
                dataBusInput <= mem[address];
                if (sync) begin
                    fetchCount <= fetchCount + 16'd1;
                end
            end else if (address >= ROM_BASE) begin
                romWriteErr <= 1'b1;
            end
        end else if (state == ST_IDLE) begin
            // Not completing from IDLE means a stall is required.
            state   <= ST_WAIT;
            ready   <= 1'b0;
            waitCnt <= WAIT_LOAD;
        end else begin
            waitCnt <= waitCnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_bus_memory_model.sv
// -----------------------------------------------------------------------------
// tb_bus_memory_model
//
// Four instances share one set of bus inputs and differ only in wait-state
// configuration:
//   0: WAIT_STATES=0                      (table vectors, random, fetch wrap)
//   1: WAIT_STATES=2                      (stall sequence)
//   2: WAIT_STATES=3, WAIT_FETCH_ONLY=1   (fetch-only stalls)
//   3: WAIT_STATES=4                      (reset while stalled)
// -----------------------------------------------------------------------------
module tb_bus_memory_model;

    logic        tb_clk = 1'b0;
    logic        nrst;
    logic [15:0] address;
    logic        readNotWrite;
    logic [7:0]  dataBusOutput;
    logic        sync;
    logic        loadEn;
    logic [15:0] loadAddr;
    logic [7:0]  loadData;

    logic [7:0]  dbi  [4];
    logic        rdy  [4];
    logic        err  [4];
    logic [15:0] fcnt [4];

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        bus_memory_model #(
            .ADDR_W         (16),
            .DATA_W         (8),
            .WAIT_STATES    (gi == 0 ? 0 : gi == 1 ? 2 : gi == 2 ? 3 : 4),
            .WAIT_FETCH_ONLY(gi == 2 ? 1 : 0),
            .ROM_BASE       (16'hC000)
        ) u_dut (
            .clk          (tb_clk),
            .nrst         (nrst),
            .address      (address),
            .readNotWrite (readNotWrite),
            .dataBusOutput(dataBusOutput),
            .sync         (sync),
            .dataBusInput (dbi[gi]),
            .ready        (rdy[gi]),
            .loadEn       (loadEn),
            .loadAddr     (loadAddr),
            .loadData     (loadData),
            .romWriteErr  (err[gi]),
            .fetchCount   (fcnt[gi])
        );
    end

    typedef struct packed {
        logic        nrst;
        logic        rnw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        sync;
        logic        le;
        logic [15:0] la;
        logic [7:0]  ld;
        logic        eRdy;
        logic [7:0]  eData;
        logic        eErr;
        logic [15:0] eCnt;
    } vecType;

    vecType      vecs [17];
    logic [7:0]  mdl  [65536];

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pick();
        if ($urandom % 2 == 0) return 16'($urandom % 8);
        return 16'hC000 | 16'($urandom % 8);
    endfunction

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [15:0] a;
        logic [15:0] la;
        logic [7:0]  d;
        logic [7:0]  ld;
        logic        rnw;
        logic        s;
        logic        le;
        logic [7:0]  expData;
        logic        expErr;
        logic [15:0] expCnt;
        int          k;

        nrst          = 1'b0;
        address       = 16'h0000;
        readNotWrite  = 1'b1;
        dataBusOutput = 8'h00;
        sync          = 1'b0;
        loadEn        = 1'b0;
        loadAddr      = 16'h0000;
        loadData      = 8'h00;

        // ---------------- reset state, all instances ----------------
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset dbi[%0d]", i),   32'(dbi[i]),  32'h00);
            chk($sformatf("reset ready[%0d]", i), 32'(rdy[i]),  32'h1);
            chk($sformatf("reset err[%0d]", i),   32'(err[i]),  32'h0);
            chk($sformatf("reset fcnt[%0d]", i),  32'(fcnt[i]), 32'h0);
        end

        // ---------------- table vectors, instance 0 ----------------
        //            nrst rnw  addr      wdata  sync le  la        ld       rdy  data   err  cnt
        vecs[0]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hFFFC, 8'hDD, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hFFFD, 8'hCC, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'hCD14, 8'h99, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0100, 8'h00, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 16'hFFFC, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hDD, 1'b0, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 16'hFFFD, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hCC, 1'b0, 16'd1};
        vecs[6]  = '{1'b1, 1'b0, 16'hCD14, 8'h55, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hCC, 1'b1, 16'd1};
        vecs[7]  = '{1'b1, 1'b1, 16'hCD14, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h99, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0100, 8'hFF, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h99, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 1'b1, 16'h0100, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hFF, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 1'b0, 16'h0300, 8'h22, 1'b0, 1'b1, 16'h0300, 8'h11, 1'b0, 8'hFF, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 1'b0, 16'h0300, 8'h22, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hFF, 1'b0, 16'd1};
        vecs[12] = '{1'b1, 1'b1, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h22, 1'b0, 16'd1};
        vecs[13] = '{1'b1, 1'b0, 16'hC000, 8'h33, 1'b0, 1'b1, 16'h0400, 8'h44, 1'b0, 8'h22, 1'b0, 16'd1};
        vecs[14] = '{1'b1, 1'b0, 16'hC000, 8'h33, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h22, 1'b1, 16'd1};
        vecs[15] = '{1'b1, 1'b1, 16'h0400, 8'h00, 1'b0, 1'b1, 16'h0400, 8'h77, 1'b1, 8'h44, 1'b0, 16'd1};
        vecs[16] = '{1'b1, 1'b1, 16'h0400, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h77, 1'b0, 16'd1};

        for (int v = 0; v < 17; v++) begin
            nrst          = vecs[v].nrst;
            readNotWrite  = vecs[v].rnw;
            address       = vecs[v].addr;
            dataBusOutput = vecs[v].wdata;
            sync          = vecs[v].sync;
            loadEn        = vecs[v].le;
            loadAddr      = vecs[v].la;
            loadData      = vecs[v].ld;
            tick();
            $display("vec %0d: nrst=%b rnw=%b addr=%h ready=%b dbi=%h err=%b fcnt=%0d",
                     v, nrst, readNotWrite, address, rdy[0], dbi[0], err[0], fcnt[0]);
            chk($sformatf("vec%0d ready", v), 32'(rdy[0]),  32'(vecs[v].eRdy));
            chk($sformatf("vec%0d dbi", v),   32'(dbi[0]),  32'(vecs[v].eData));
            chk($sformatf("vec%0d err", v),   32'(err[0]),  32'(vecs[v].eErr));
            chk($sformatf("vec%0d fcnt", v),  32'(fcnt[0]), 32'(vecs[v].eCnt));
        end
        loadEn = 1'b0;

        // ---------------- randomized transactions vs model, instance 0 ----------------
        nrst         = 1'b0;
        readNotWrite = 1'b1;
        sync         = 1'b0;
        for (int i = 0; i < 16; i++) begin
            loadAddr = (i < 8) ? 16'(i) : (16'hC000 | 16'(i - 8));
            loadData = 8'($urandom);
            loadEn   = 1'b1;
            mdl[loadAddr] = loadData;
            tick();
        end
        loadEn = 1'b0;
        tick();
        nrst    = 1'b1;
        expData = 8'h00;
        expCnt  = 16'd0;

        for (int n = 0; n < 300; n++) begin
            a   = pick();
            rnw = 1'($urandom);
            d   = 8'($urandom);
            s   = rnw & 1'($urandom);
            le  = ($urandom % 4 == 0);
            la  = pick();
            ld  = 8'($urandom);

            address       = a;
            readNotWrite  = rnw;
            dataBusOutput = d;
            sync          = s;
            loadEn        = le;
            loadAddr      = la;
            loadData      = ld;
            expErr        = 1'b0;

            if (rnw) expData = mdl[a];
            if (le) mdl[la] = ld;
            tick();
            if (!rnw && le) begin
                chk($sformatf("rnd%0d deferred ready", n), 32'(rdy[0]), 32'h0);
                chk($sformatf("rnd%0d deferred err", n),   32'(err[0]), 32'h0);
                loadEn = 1'b0;
                tick();
            end
            if (!rnw) begin
                if (a < 16'hC000) mdl[a] = d;
                else expErr = 1'b1;
            end else if (s) begin
                expCnt = expCnt + 16'd1;
            end
            $display("rnd %0d: rnw=%b addr=%h wdata=%h sync=%b load=%b@%h ready=%b dbi=%h err=%b fcnt=%0d",
                     n, rnw, a, d, s, le, la, rdy[0], dbi[0], err[0], fcnt[0]);
            chk($sformatf("rnd%0d ready", n), 32'(rdy[0]),  32'h1);
            chk($sformatf("rnd%0d dbi", n),   32'(dbi[0]),  32'(expData));
            chk($sformatf("rnd%0d err", n),   32'(err[0]),  32'(expErr));
            chk($sformatf("rnd%0d fcnt", n),  32'(fcnt[0]), 32'(expCnt));
        end
        loadEn = 1'b0;

        // ---------------- WAIT_STATES=2, instance 1 ----------------
        nrst         = 1'b0;
        readNotWrite = 1'b1;
        sync         = 1'b0;
        loadEn       = 1'b1;
        loadAddr = 16'hCCDD; loadData = 8'h90; tick();
        loadAddr = 16'h0100; loadData = 8'hFF; tick();
        loadAddr = 16'h0200; loadData = 8'h00; tick();
        loadEn = 1'b0;
        tick();
        nrst    = 1'b1;
        address = 16'hCCDD;
        sync    = 1'b1;
        tick();
        chk("ws2 edge1 ready", 32'(rdy[1]), 32'h0);
        tick();
        chk("ws2 edge2 ready", 32'(rdy[1]), 32'h0);
        tick();
        $display("ws2 read CCDD: ready=%b dbi=%h fcnt=%0d", rdy[1], dbi[1], fcnt[1]);
        chk("ws2 edge3 ready", 32'(rdy[1]),  32'h1);
        chk("ws2 dbi",         32'(dbi[1]),  32'h90);
        chk("ws2 fcnt",        32'(fcnt[1]), 32'h1);

        // ---------------- WAIT_FETCH_ONLY=1, WAIT_STATES=3, instance 2 ----------------
        nrst = 1'b0;
        tick();
        nrst    = 1'b1;
        address = 16'h0100;
        sync    = 1'b0;
        tick();
        $display("wfo read 0100 sync=0: ready=%b dbi=%h", rdy[2], dbi[2]);
        chk("wfo nosync ready", 32'(rdy[2]), 32'h1);
        chk("wfo nosync dbi",   32'(dbi[2]), 32'hFF);
        address = 16'hCCDD;
        sync    = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("wfo sync stall%0d ready", e), 32'(rdy[2]), 32'h0);
        end
        tick();
        $display("wfo read CCDD sync=1: ready=%b dbi=%h fcnt=%0d", rdy[2], dbi[2], fcnt[2]);
        chk("wfo sync ready", 32'(rdy[2]),  32'h1);
        chk("wfo sync dbi",   32'(dbi[2]),  32'h90);
        chk("wfo sync fcnt",  32'(fcnt[2]), 32'h1);

        // ---------------- reset while stalled, WAIT_STATES=4, instance 3 ----------------
        nrst = 1'b0;
        tick();
        nrst          = 1'b1;
        address       = 16'h0200;
        readNotWrite  = 1'b0;
        dataBusOutput = 8'hAA;
        sync          = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("midrst stall%0d ready", e), 32'(rdy[3]), 32'h0);
        end
        nrst = 1'b0;
        tick();
        $display("midrst reset edge: ready=%b fcnt=%0d", rdy[3], fcnt[3]);
        chk("midrst ready", 32'(rdy[3]),  32'h1);
        chk("midrst fcnt",  32'(fcnt[3]), 32'h0);
        nrst         = 1'b1;
        readNotWrite = 1'b1;
        k = 0;
        tick();
        while (!rdy[3] && k < 10) begin
            tick();
            k++;
        end
        $display("midrst readback 0200: ready=%b dbi=%h", rdy[3], dbi[3]);
        chk("midrst readback timeout", 32'(rdy[3]), 32'h1);
        chk("midrst readback dbi",     32'(dbi[3]), 32'h00);

        // ---------------- fetch counter wrap, instance 0 ----------------
        nrst = 1'b0;
        tick();
        nrst         = 1'b1;
        address      = 16'h0000;
        readNotWrite = 1'b1;
        sync         = 1'b1;
        repeat (65535) tick();
        $display("wrap: fcnt=%h after 65535 fetches", fcnt[0]);
        chk("wrap ffff", 32'(fcnt[0]), 32'hFFFF);
        tick();
        $display("wrap: fcnt=%h after 65536 fetches", fcnt[0]);
        chk("wrap 0000", 32'(fcnt[0]), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
